grey_dec_counter: RTL and testbench
===================================

Name: grey_dec_counter

Overview:
- Parametrised multi-digit decimal counter; each digit is held in the team's 5-bit single-bit-change decimal code.
- Successor to the fixed 9-digit up-only counter. Adds:
  - configurable digit count
  - count enable, up/down direction, parallel load with sanitising, synchronous clear
  - wrap or saturate mode, wrap/terminal-count flags
- Feeds display and readout logic that decodes per-digit codes.

Parameters:
- DIGITS, 9, number of decimal digits (1..16).
- SATURATE, 0, 0 = wrap at boundary; 1 = hold at boundary.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_clr  input  1  synchronous clear to all-zero
- i_en  input  1  count enable, one step per cycle when high
- i_up  input  1  direction: 1 = increment, 0 = decrement
- i_load  input  1  synchronous parallel load
- i_load_val  input  5*DIGITS  load value; digit k in bits [5k+4:5k]
- o_count  output  5*DIGITS  current count; digit 0 (ones) in bits [4:0]
- o_tc  output  1  terminal count for current direction (combinational)
- o_wrap  output  1  registered one-cycle boundary flag
- o_load_err  output  1  registered one-cycle flag: illegal code in load value

Behaviour:
- Digit code sequence 0..9:
  - 00000, 00001, 00011, 00010, 00110, 00100, 01100, 01000, 11000, 10000
  - 9 -> 0 and 0 -> 9 are also single-bit changes.
- Per-digit next-state functions:
  - inc(d) follows the sequence.
  - dec(d) runs it in reverse.
  - Any code not in the table maps to 00000 in both.
- Reset:
  - i_rst_n low: o_count = 0 (all digits 00000), o_wrap = 0, o_load_err = 0, immediately and independent of i_clk.
  - Deassertion takes effect at the next rising edge.
- Priority per edge: i_clr > i_load > i_en. Nothing changes when none is high.
- Clear: all digits <= 00000; o_wrap <= 0; o_load_err <= 0.
- Load:
  - Each digit <= i_load_val digit when the code is legal, else 00000.
  - o_load_err <= 1 when any digit was illegal, else 0.
  - o_wrap <= 0.
  - i_en is ignored that cycle.
- Count up (i_en=1, i_up=1):
  - Digit 0 increments.
  - Digit k increments iff all digits below k are 9 (10000); those lower digits become 00000.
  - Higher digits hold.
- Count down (i_en=1, i_up=0):
  - Digit 0 decrements.
  - Digit k decrements iff all digits below k are 0; those lower digits become 9 (10000).
- Boundary, up at all-9:
  - SATURATE=0: count becomes all-0.
  - SATURATE=1: count holds.
  - Either mode: o_wrap <= 1.
- Boundary, down at all-0:
  - SATURATE=0: count becomes all-9.
  - SATURATE=1: count holds.
  - Either mode: o_wrap <= 1.
- o_wrap is high for exactly one cycle per boundary step. It is 0 on any non-boundary step and on idle cycles.
- o_load_err is 0 on every cycle that is not a load.
- o_tc is combinational from the current count: 1 iff (i_up and all digits 10000) or (!i_up and all digits 00000).
- Latency: o_count reflects a step on the edge where i_en is sampled high. No pipeline stages.
- Direction change mid-count: takes effect on the same edge it is sampled; no turnaround cycle.
- Illegal codes cannot appear in o_count. Load sanitises them, and inc/dec map them to 0 defensively.
- Async reset asserted mid-operation aborts any step. No partial digit update is visible.

Test Plan:
- Reset/idle:
  - Stimulus: hold i_rst_n=0 with clock running.
  - Required: o_count=0, o_wrap=0, o_load_err=0; o_tc=1 when i_up=0.
  - Release, i_en=0 for 5 cycles: count stays 0.
- Carry chain, DIGITS=3, up:
  - Stimulus: load 099 = {00000,10000,10000}, then one i_en pulse.
  - Required: o_count = 100 = {00001,00000,00000}, o_wrap=0.
  - Stimulus: count from 000 for 12 cycles.
  - Required: ones digit passes 00000..10000 then 00000; tens = 00001 at step 10.
- Borrow/wrap, DIGITS=3, SATURATE=0, down:
  - Stimulus: load 100, step down.
  - Required: 099.
  - Stimulus: from 000, step down.
  - Required: 999 = all 10000, o_wrap=1 for one cycle.
  - Stimulus: load 999, step up.
  - Required: 000, o_wrap=1.
- Saturate, SATURATE=1:
  - Stimulus: at 999, i_up=1, i_en=1 for 3 cycles.
  - Required: count holds 999, o_wrap=1 each cycle, o_tc=1.
  - Stimulus: at 000, i_up=0.
  - Required: count holds 000.
- Load sanitise/priority:
  - Stimulus: i_load_val digits {00101,00011,11111}.
  - Required: count = {00000,00011,00000}, o_load_err=1 for one cycle.
  - Stimulus: i_clr=1, i_load=1, i_en=1 together.
  - Required: count 000.
- Async reset mid-count:
  - Stimulus: count up, drop i_rst_n between edges.
  - Required: o_count=0 before the next edge; resumes from 000 after release.

Source files
------------

// File: rtl/grey_dec_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : grey_dec_counter_if
// Brief    : Control/status bundle for the multi-digit single-bit-change
//            decimal counter.
// Revision : 1.0 - initial release
// ============================================================================
interface grey_dec_counter_if #(
    parameter int DIGITS = 9
);
    logic                  i_clr;
    logic                  i_en;
    logic                  i_up;
    logic                  i_load;
    logic [5*DIGITS-1:0]   i_load_val;
    logic [5*DIGITS-1:0]   o_count;
    logic                  o_tc;
    logic                  o_wrap;
    logic                  o_load_err;

    modport master (
        output i_clr,
        output i_en,
        output i_up,
        output i_load,
        output i_load_val,
        input  o_count,
        input  o_tc,
        input  o_wrap,
        input  o_load_err
    );

    modport slave (
        input  i_clr,
        input  i_en,
        input  i_up,
        input  i_load,
        input  i_load_val,
        output o_count,
        output o_tc,
        output o_wrap,
        output o_load_err
    );
endinterface
`default_nettype wire

// File: rtl/grey_dec_counter.sv
`default_nettype none
// ============================================================================
// Module   : grey_dec_counter
// Brief    : Parametrised up/down decimal counter, each digit held in a 5-bit
//            single-bit-change code; load sanitising, wrap or saturate.
// Revision : 1.0 - initial release
// ============================================================================
module grey_dec_counter #(
    parameter int DIGITS   = 9,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    grey_dec_counter_if.slave     bus
);

    localparam logic [4:0] C_D0 = 5'b00000;
    localparam logic [4:0] C_D1 = 5'b00001;
    localparam logic [4:0] C_D2 = 5'b00011;
    localparam logic [4:0] C_D3 = 5'b00010;
    localparam logic [4:0] C_D4 = 5'b00110;
    localparam logic [4:0] C_D5 = 5'b00100;
    localparam logic [4:0] C_D6 = 5'b01100;
    localparam logic [4:0] C_D7 = 5'b01000;
    localparam logic [4:0] C_D8 = 5'b11000;
    localparam logic [4:0] C_D9 = 5'b10000;

    function automatic logic f_is_legal(input logic [4:0] d);
        case (d)
            C_D0, C_D1, C_D2, C_D3, C_D4,
            C_D5, C_D6, C_D7, C_D8, C_D9: f_is_legal = 1'b1;
            default:                      f_is_legal = 1'b0;
        endcase
    endfunction

    // Unknown codes fall back to zero so a corrupted digit self-heals.
    function automatic logic [4:0] f_inc(input logic [4:0] d);
        case (d)
            C_D0:    f_inc = C_D1;
            C_D1:    f_inc = C_D2;
            C_D2:    f_inc = C_D3;
            C_D3:    f_inc = C_D4;
            C_D4:    f_inc = C_D5;
            C_D5:    f_inc = C_D6;
            C_D6:    f_inc = C_D7;
            C_D7:    f_inc = C_D8;
            C_D8:    f_inc = C_D9;
            C_D9:    f_inc = C_D0;
            default: f_inc = C_D0;
        endcase
    endfunction

    function automatic logic [4:0] f_dec(input logic [4:0] d);
        case (d)
            C_D0:    f_dec = C_D9;
            C_D1:    f_dec = C_D0;
            C_D2:    f_dec = C_D1;
            C_D3:    f_dec = C_D2;
            C_D4:    f_dec = C_D3;
            C_D5:    f_dec = C_D4;
            C_D6:    f_dec = C_D5;
            C_D7:    f_dec = C_D6;
            C_D8:    f_dec = C_D7;
            C_D9:    f_dec = C_D8;
            default: f_dec = C_D0;
        endcase
    endfunction

    logic [5*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic                r_load_err;

    logic [DIGITS-1:0]   w_is9;
    logic [DIGITS-1:0]   w_is0;
    logic [DIGITS-1:0]   w_illegal;
    logic [DIGITS:0]     w_all9_below;
    logic [DIGITS:0]     w_all0_below;
    logic [5*DIGITS-1:0] w_step;
    logic [5*DIGITS-1:0] w_sanitised;
    logic                w_boundary;
    logic                w_any_illegal;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [4:0] w_d;
            logic [4:0] w_ld;

            assign w_d          = r_count[5*k +: 5];
            assign w_ld         = bus.i_load_val[5*k +: 5];
            assign w_is9[k]     = (w_d == C_D9);
            assign w_is0[k]     = (w_d == C_D0);
            assign w_illegal[k] = !f_is_legal(w_ld);
            assign w_sanitised[5*k +: 5] = w_illegal[k] ? C_D0 : w_ld;

            // A digit moves only when every lower digit is rolling over.
            assign w_step[5*k +: 5] = bus.i_up
                ? (w_all9_below[k] ? f_inc(w_d) : w_d)
                : (w_all0_below[k] ? f_dec(w_d) : w_d);
        end
    endgenerate

    always_comb begin
        w_all9_below    = '0;
        w_all0_below    = '0;
        w_all9_below[0] = 1'b1;
        w_all0_below[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_all9_below[k+1] = w_all9_below[k] & w_is9[k];
            w_all0_below[k+1] = w_all0_below[k] & w_is0[k];
        end
    end

    assign w_boundary    = bus.i_up ? w_all9_below[DIGITS] : w_all0_below[DIGITS];
    assign w_any_illegal = |w_illegal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.i_clr) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.i_load) begin
            r_count    <= w_sanitised;
            r_wrap     <= 1'b0;
            r_load_err <= w_any_illegal;
        end else if (bus.i_en) begin
            // In wrap mode the natural carry/borrow already lands on all-0/all-9.
            if (!(SATURATE && w_boundary)) begin
                r_count <= w_step;
            end
            r_wrap     <= w_boundary;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign bus.o_count    = r_count;
    assign bus.o_tc       = w_boundary;
    assign bus.o_wrap     = r_wrap;
    assign bus.o_load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_grey_dec_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grey_dec_counter
// Brief    : Bench for grey_dec_counter, wrap and saturate variants side by
//            side against an integer-valued decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grey_dec_counter;

    localparam int ND   = 3;
    localparam int W    = 5*ND;
    localparam int MAXV = (10**ND) - 1;

    logic clk;
    logic rst_n;

    grey_dec_counter_if #(.DIGITS(ND)) b0 ();
    grey_dec_counter_if #(.DIGITS(ND)) b1 ();

    grey_dec_counter #(.DIGITS(ND), .SATURATE(1'b0)) u_wrap (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b0)
    );

    grey_dec_counter #(.DIGITS(ND), .SATURATE(1'b1)) u_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] code_tab [10];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  m0, m1;
    bit  mw0, mw1, me;

    function automatic logic [W-1:0] enc(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < ND; k++) begin
            r[5*k +: 5] = code_tab[t % 10];
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check_all(input bit up);
        logic [W-1:0] e0, e1;
        e0 = enc(m0);
        e1 = enc(m1);
        n_assert++; assert (b0.o_count === e0) else begin n_fail++; $error("FAIL count_wrap observed=%b expected=%b", b0.o_count, e0); end
        n_assert++; assert (b1.o_count === e1) else begin n_fail++; $error("FAIL count_sat observed=%b expected=%b", b1.o_count, e1); end
        n_assert++; assert (b0.o_wrap === mw0) else begin n_fail++; $error("FAIL wrap_wrap observed=%b expected=%b", b0.o_wrap, mw0); end
        n_assert++; assert (b1.o_wrap === mw1) else begin n_fail++; $error("FAIL wrap_sat observed=%b expected=%b", b1.o_wrap, mw1); end
        n_assert++; assert (b0.o_load_err === me) else begin n_fail++; $error("FAIL lerr_wrap observed=%b expected=%b", b0.o_load_err, me); end
        n_assert++; assert (b1.o_load_err === me) else begin n_fail++; $error("FAIL lerr_sat observed=%b expected=%b", b1.o_load_err, me); end
        n_assert++; assert (b0.o_tc === (up ? (m0 == MAXV) : (m0 == 0))) else begin n_fail++; $error("FAIL tc_wrap observed=%b expected=%b", b0.o_tc, up ? (m0 == MAXV) : (m0 == 0)); end
        n_assert++; assert (b1.o_tc === (up ? (m1 == MAXV) : (m1 == 0))) else begin n_fail++; $error("FAIL tc_sat observed=%b expected=%b", b1.o_tc, up ? (m1 == MAXV) : (m1 == 0)); end
    endtask

    // Apply one cycle of controls, advance the model, check after the edge.
    task automatic drive(input bit clr, input bit load, input bit en, input bit up, input logic [W-1:0] lv);
        int  v, found, pw;
        bit  err;
        b0.i_clr = clr; b0.i_load = load; b0.i_en = en; b0.i_up = up; b0.i_load_val = lv;
        b1.i_clr = clr; b1.i_load = load; b1.i_en = en; b1.i_up = up; b1.i_load_val = lv;
        if (clr) begin
            m0 = 0; m1 = 0; mw0 = 0; mw1 = 0; me = 0;
        end else if (load) begin
            v = 0; pw = 1; err = 0;
            for (int k = 0; k < ND; k++) begin
                found = -1;
                for (int i = 0; i < 10; i++) if (code_tab[i] == lv[5*k +: 5]) found = i;
                if (found < 0) err = 1;
                else v = v + found * pw;
                pw = pw * 10;
            end
            m0 = v; m1 = v; me = err; mw0 = 0; mw1 = 0;
        end else if (en) begin
            me = 0;
            if (up) begin
                if (m0 == MAXV) begin m0 = 0; mw0 = 1; end else begin m0 = m0 + 1; mw0 = 0; end
                if (m1 == MAXV) mw1 = 1; else begin m1 = m1 + 1; mw1 = 0; end
            end else begin
                if (m0 == 0) begin m0 = MAXV; mw0 = 1; end else begin m0 = m0 - 1; mw0 = 0; end
                if (m1 == 0) mw1 = 1; else begin m1 = m1 - 1; mw1 = 0; end
            end
        end else begin
            mw0 = 0; mw1 = 0; me = 0;
        end
        @(posedge clk);
        #1;
        check_all(up);
    endtask

    function automatic logic [W-1:0] rand_load();
        logic [W-1:0] r;
        int s;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            s = $urandom_range(0, 19);
            if (s < 4)       r[5*k +: 5] = code_tab[9];
            else if (s < 8)  r[5*k +: 5] = code_tab[0];
            else if (s < 18) r[5*k +: 5] = code_tab[$urandom_range(0, 9)];
            else             r[5*k +: 5] = 5'($urandom);
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit up_dir;
        int r;
        code_tab[0] = 5'b00000; code_tab[1] = 5'b00001; code_tab[2] = 5'b00011;
        code_tab[3] = 5'b00010; code_tab[4] = 5'b00110; code_tab[5] = 5'b00100;
        code_tab[6] = 5'b01100; code_tab[7] = 5'b01000; code_tab[8] = 5'b11000;
        code_tab[9] = 5'b10000;
        m0 = 0; m1 = 0; mw0 = 0; mw1 = 0; me = 0;

        rst_n = 1'b0;
        b0.i_clr = 0; b0.i_load = 0; b0.i_en = 0; b0.i_up = 0; b0.i_load_val = '0;
        b1.i_clr = 0; b1.i_load = 0; b1.i_en = 0; b1.i_up = 0; b1.i_load_val = '0;

        // Reset held with clock running; tc high for down direction at zero
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0);
        rst_n = 1'b1;
        repeat (5) drive(0, 0, 0, 0, '0);

        // Carry chain: 099 -> 100
        drive(0, 1, 0, 1, enc(99));
        drive(0, 0, 1, 1, '0);
        drive(1, 0, 0, 1, '0);
        repeat (12) drive(0, 0, 1, 1, '0);

        // Borrow and wrap boundaries
        drive(0, 1, 0, 0, enc(100));
        drive(0, 0, 1, 0, '0);
        drive(1, 0, 0, 0, '0);
        drive(0, 0, 1, 0, '0);
        drive(0, 1, 0, 1, enc(999));
        drive(0, 0, 1, 1, '0);

        // Saturate holds at all-9 for several cycles
        drive(0, 1, 0, 1, enc(999));
        repeat (3) drive(0, 0, 1, 1, '0);
        drive(1, 0, 0, 0, '0);
        repeat (2) drive(0, 0, 1, 0, '0);
        drive(0, 0, 0, 0, '0);

        // Load sanitising, then error flag drops
        drive(0, 1, 0, 1, {5'b00101, 5'b00011, 5'b11111});
        drive(0, 0, 0, 1, '0);

        // Priority: clear wins over load and enable
        drive(0, 1, 0, 1, enc(457));
        drive(1, 1, 1, 1, enc(321));
        drive(0, 1, 1, 1, enc(321));

        // Async reset mid-count
        repeat (4) drive(0, 0, 1, 1, '0);
        #3;
        rst_n = 1'b0;
        #1;
        m0 = 0; m1 = 0; mw0 = 0; mw1 = 0; me = 0;
        check_all(1'b1);
        @(posedge clk);
        #1;
        check_all(1'b1);
        rst_n = 1'b1;
        repeat (3) drive(0, 0, 1, 1, '0);

        // Randomized operation
        up_dir = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) up_dir = ~up_dir;
            r = $urandom_range(0, 99);
            drive(r < 2, (r >= 1) && (r < 12), $urandom_range(0, 9) < 8, up_dir, rand_load());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
